// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack front end: request opcodes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package stack_ctrl_pkg;

    // Request opcodes as carried on req_op
    typedef enum logic [1:0] {
        OP_PEEK = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

    // Sequencer states; the stack strobes are decoded directly from these
    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_POP_CYC  = 2'b01,
        S_PUSH_CYC = 2'b10,
        S_RESP     = 2'b11
    } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Request/response sequencer in front of a shift-register stack; tracks depth, blocks over/underflow.
// Latency: PEEK/error 1 cycle, PUSH/POP 2 cycles, SWAP 3 cycles from accept to resp_valid.
// Backpressure: one request in flight; req_ready low until the response is taken via resp_ready.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter  int length     = 8,
    parameter  int data_width = 8,
    localparam int cnt_width  = $clog2(length + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [data_width-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [data_width-1:0] resp_data,
    output logic                  resp_err,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [data_width-1:0] stk_data_IN,
    input  logic [data_width-1:0] stk_data_OUT,
    output logic [cnt_width-1:0]  depth,
    output logic                  full,
    output logic                  empty,
    output logic                  err_overflow,
    output logic                  err_underflow,
    input  logic                  err_clr
);

    state_e                state_q;
    op_e                   op_q;
    logic [data_width-1:0] resp_data_q;
    logic [data_width-1:0] stk_data_in_q;
    logic                  resp_err_q;
    logic [cnt_width-1:0]  depth_q;
    logic                  ovf_q;
    logic                  unf_q;

    op_e  req_op_e;
    logic accept;
    logic acc_ovf;
    logic acc_unf;
    logic acc_err;

    assign req_op_e = op_e'(req_op);
    assign accept   = req_valid & req_ready;
    // Errors are judged against the depth seen at the accepting edge
    assign acc_ovf  = accept && (req_op_e == OP_PUSH) && full;
    assign acc_unf  = accept && (req_op_e != OP_PUSH) && empty;
    assign acc_err  = acc_ovf | acc_unf;

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = (state_q == S_RESP);
    assign resp_data     = resp_data_q;
    assign resp_err      = resp_err_q;
    assign stk_push      = (state_q == S_PUSH_CYC);
    assign stk_pop       = (state_q == S_POP_CYC);
    assign stk_data_IN   = stk_data_in_q;
    assign depth         = depth_q;
    assign full          = (depth_q == cnt_width'(length));
    assign empty         = (depth_q == '0);
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

    // Sequencer: accept, stack strobe cycles, response hold; depth moves with the strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            op_q          <= OP_PEEK;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
            stk_data_in_q <= '0;
            depth_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q          <= req_op_e;
                        stk_data_in_q <= req_data;
                        resp_err_q    <= acc_err;
                        // The top is captured now; a POP/SWAP strobe changes it later
                        resp_data_q   <= (acc_err || req_op_e == OP_PUSH) ? '0 : stk_data_OUT;
                        if (acc_err) begin
                            state_q <= S_RESP;
                        end else begin
                            case (req_op_e)
                                OP_PEEK: state_q <= S_RESP;
                                OP_PUSH: state_q <= S_PUSH_CYC;
                                default: state_q <= S_POP_CYC;
                            endcase
                        end
                    end
                end
                S_POP_CYC: begin
                    depth_q <= depth_q - cnt_width'(1);
                    state_q <= (op_q == OP_SWAP) ? S_PUSH_CYC : S_RESP;
                end
                S_PUSH_CYC: begin
                    depth_q <= depth_q + cnt_width'(1);
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle beats the clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (acc_ovf) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (acc_unf) begin
                unf_q <= 1'b1;
            end else if (err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl driving a behavioural 8x8 shift-register stack.
// Latency: checks response latency per opcode and strobe placement.
// Backpressure: exercises a held resp_ready=0 window.
module tb_stack_ctrl;
    import stack_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_data = 8'h00;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [7:0] resp_data;
    logic       resp_err;
    logic       stk_push;
    logic       stk_pop;
    logic [7:0] stk_data_IN;
    logic [7:0] stk_data_OUT;
    logic [3:0] depth;
    logic       full;
    logic       empty;
    logic       err_overflow;
    logic       err_underflow;
    logic       err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;

    always #5 clk = ~clk;

    stack_ctrl #(.length(8), .data_width(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_data      (req_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_data_IN   (stk_data_IN),
        .stk_data_OUT  (stk_data_OUT),
        .depth         (depth),
        .full          (full),
        .empty         (empty),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_clr       (err_clr)
    );

    // Behavioural downstream stack: entry 0 is the top
    logic [7:0] stk_mem [8];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) stk_mem[i] <= 8'h00;
        end else if (stk_push) begin
            for (int i = 7; i > 0; i--) stk_mem[i] <= stk_mem[i-1];
            stk_mem[0] <= stk_data_IN;
        end else if (stk_pop) begin
            for (int i = 0; i < 7; i++) stk_mem[i] <= stk_mem[i+1];
            stk_mem[7] <= 8'h00;
        end
    end
    assign stk_data_OUT = stk_mem[0];

    // Free-running strobe counters; requests compare before/after deltas
    always @(posedge clk) begin
        if (stk_push) push_cnt <= push_cnt + 1;
        if (stk_pop)  pop_cnt  <= pop_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Issue one request with resp_ready=1; starts and ends #1 after a clock edge in IDLE
    task automatic do_req(input string tag, input logic [1:0] op, input logic [7:0] d,
                          input logic [7:0] exp_d, input logic exp_err);
        int lat;
        int exp_lat;
        int p0;
        int q0;
        logic exp_push1;
        logic exp_pop1;
        p0 = push_cnt;
        q0 = pop_cnt;
        chk({tag, ".req_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_push1 = !exp_err && (op == 2'b01);
        exp_pop1  = !exp_err && (op == 2'b10 || op == 2'b11);
        chk({tag, ".push_t1"}, stk_push, exp_push1);
        chk({tag, ".pop_t1"},  stk_pop,  exp_pop1);
        if (exp_err || op == 2'b00) exp_lat = 1;
        else if (op == 2'b11)       exp_lat = 3;
        else                        exp_lat = 2;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".resp_data"}, resp_data, exp_d);
        chk({tag, ".resp_err"}, resp_err, exp_err);
        @(posedge clk); #1;
        chk({tag, ".idle_after"}, req_ready, 1);
        chk({tag, ".n_push"}, push_cnt - p0, (!exp_err && (op == 2'b01 || op == 2'b11)) ? 1 : 0);
        chk({tag, ".n_pop"},  pop_cnt - q0,  (!exp_err && (op == 2'b10 || op == 2'b11)) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready", req_ready, 1);
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.resp_data", resp_data, 0);
        chk("rst.resp_err", resp_err, 0);
        chk("rst.strobes", {stk_push, stk_pop}, 0);
        chk("rst.stk_data_IN", stk_data_IN, 0);
        chk("rst.depth", depth, 0);
        chk("rst.empty_full", {empty, full}, 2'b10);
        chk("rst.sticky", {err_overflow, err_underflow}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic pushes and peek
        do_req("push11", 2'b01, 8'h11, 8'h00, 1'b0);
        do_req("push22", 2'b01, 8'h22, 8'h00, 1'b0);
        do_req("push33", 2'b01, 8'h33, 8'h00, 1'b0);
        chk("depth3", depth, 3);
        do_req("peek33", 2'b00, 8'h00, 8'h33, 1'b0);
        chk("peek.depth", depth, 3);

        // Pops down to empty, then underflow
        do_req("pop33", 2'b10, 8'h00, 8'h33, 1'b0);
        chk("pop.depth2", depth, 2);
        do_req("pop22", 2'b10, 8'h00, 8'h22, 1'b0);
        chk("pop.depth1", depth, 1);
        do_req("pop11", 2'b10, 8'h00, 8'h11, 1'b0);
        chk("pop.depth0", depth, 0);
        chk("pop.empty", empty, 1);
        do_req("pop_unf", 2'b10, 8'h00, 8'h00, 1'b1);
        chk("unf.flag", err_underflow, 1);
        chk("unf.no_ovf", err_overflow, 0);
        chk("unf.depth", depth, 0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("unf.cleared", err_underflow, 0);

        // Fill, overflow, swap while full
        for (int i = 1; i <= 8; i++) do_req("fill", 2'b01, 8'(i), 8'h00, 1'b0);
        chk("fill.depth", depth, 8);
        chk("fill.full", {full, empty}, 2'b10);
        do_req("push_ovf", 2'b01, 8'hFF, 8'h00, 1'b1);
        chk("ovf.flag", err_overflow, 1);
        chk("ovf.depth", depth, 8);
        do_req("swapAA", 2'b11, 8'hAA, 8'h08, 1'b0);
        chk("swap.depth", depth, 8);
        do_req("peekAA", 2'b00, 8'h00, 8'hAA, 1'b0);

        // Response backpressure on a POP
        begin
            int q0;
            q0 = pop_cnt;
            resp_ready = 1'b0;
            req_valid  = 1'b1;
            req_op     = 2'b10;
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk("bp.pop_t1", stk_pop, 1);
            @(posedge clk); #1;
            chk("bp.resp_valid", resp_valid, 1);
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                chk("bp.hold_valid", resp_valid, 1);
                chk("bp.hold_data", resp_data, 8'hAA);
                chk("bp.hold_ready", req_ready, 0);
                chk("bp.hold_depth", depth, 7);
            end
            resp_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp.idle", req_ready, 1);
            chk("bp.valid_low", resp_valid, 0);
            chk("bp.n_pop", pop_cnt - q0, 1);
        end

        // Set beats clear on the sticky overflow flag
        do_req("push09", 2'b01, 8'h09, 8'h00, 1'b0);
        chk("refill.full", full, 1);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_data  = 8'h55;
        err_clr   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("clr.set_wins", err_overflow, 1);
        chk("clr.resp_err", {resp_valid, resp_err}, 2'b11);
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("clr.cleared", err_overflow, 0);
        chk("clr.depth", depth, 8);

        // Reset in the middle of a SWAP
        req_valid = 1'b1;
        req_op    = 2'b11;
        req_data  = 8'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rswap.pop", stk_pop, 1);
        @(posedge clk); #1;
        chk("rswap.push", stk_push, 1);
        rst = 1'b0;
        #1;
        chk("rswap.strobes", {stk_push, stk_pop}, 0);
        chk("rswap.depth", depth, 0);
        chk("rswap.valid", resp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rswap.no_resp", resp_valid, 0);
        end
        chk("rswap.idle", req_ready, 1);
        do_req("post_push", 2'b01, 8'h42, 8'h00, 1'b0);
        do_req("post_peek", 2'b00, 8'h00, 8'h42, 1'b0);
        chk("post.depth", depth, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Request/response front end that sits directly upstream of the shift-register Stack (length 8, data_width 8). Accepts PEEK/PUSH/POP/SWAP commands over a valid/ready handshake and sequences the stack's push/pop strobes. Tracks occupancy, blocks overflow/underflow, and returns the top-of-stack value to the requester. The stack's own reset is driven at top level from ~rst; this block never drives it.

Parameters:
length, 8, stack depth; must equal the downstream Stack length
data_width, 8, data word width; must equal the downstream Stack data_width
cnt_width, $clog2(length+1), width of the occupancy counter (derived, not overridden)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  2  00 PEEK, 01 PUSH, 10 POP, 11 SWAP (replace top, return old top)
req_data  in  data_width  push/swap operand
resp_valid  out  1  response present
resp_ready  in  1  requester takes response
resp_data  out  data_width  top value read (PEEK/POP/SWAP); 0 for PUSH and on error
resp_err  out  1  request rejected (overflow/underflow)
stk_push  out  1  to Stack push
stk_pop  out  1  to Stack pop
stk_data_IN  out  data_width  to Stack data_IN
stk_data_OUT  in  data_width  from Stack data_OUT (current top)
depth  out  cnt_width  entries held
full  out  1  depth == length
empty  out  1  depth == 0
err_overflow  out  1  sticky: PUSH attempted while full
err_underflow  out  1  sticky: PEEK/POP/SWAP attempted while empty
err_clr  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (rst=0, async): state IDLE, depth 0, req_ready 1, resp_valid 0, resp_data 0, resp_err 0, stk_push 0, stk_pop 0, stk_data_IN 0, empty 1, full 0, sticky flags 0. Reset mid-operation abandons the request; no response is issued.
- States: IDLE, POP_CYC, PUSH_CYC, RESP. req_ready = (state==IDLE). A request is accepted at edge T when req_valid & req_ready.
- Accept: latch op, req_data into stk_data_IN, stk_data_OUT into the resp_data holding register.
- Error check at accept: PUSH with full, or non-PUSH with empty -> go to RESP with resp_err=1, resp_data=0; set the matching sticky flag; no stack strobes; depth unchanged.
- PEEK: IDLE->RESP; resp_valid at T+1 with the top latched at T.
- PUSH: IDLE->PUSH_CYC (stk_push=1 for exactly one cycle, depth+1)->RESP; resp_valid at T+2, resp_data=0.
- POP: IDLE->POP_CYC (stk_pop=1 for one cycle, depth-1)->RESP; resp_valid at T+2 with the old top.
- SWAP: IDLE->POP_CYC->PUSH_CYC->RESP; resp_valid at T+3 with the old top; net depth unchanged. Legal when full.
- stk_push and stk_pop are decoded from registered state, never asserted together, and are 0 outside PUSH_CYC/POP_CYC.
- RESP: resp_valid, resp_data and resp_err are held stable until resp_valid & resp_ready; the next state is IDLE. A new request can be accepted at the earliest one cycle after the response handshake.
- depth saturates by construction: it never exceeds length and never underflows. full and empty are combinational from depth.
- Sticky flags: set on error accept; cleared by err_clr; set wins over err_clr in the same cycle.

Decomposition:
- Package stack_ctrl_pkg holds the op encodings (OP_PEEK, OP_PUSH, OP_POP, OP_SWAP) and state encodings (S_IDLE, S_POP_CYC, S_PUSH_CYC, S_RESP).
- No sub-module is needed. FSM, depth counter and response register live in one module; the testbench instantiates stack_ctrl plus Stack together.

Test Plan:
- Reset, then PUSH 0x11, 0x22, 0x33 with resp_ready=1 -> stk_push one cycle each at T+1; resp_valid at T+2; depth=3; PEEK returns 0x33.
- POP x3 -> resp_data 0x33, 0x22, 0x11; depth goes 2,1,0; empty=1; a fourth POP gives resp_err=1, resp_data=0, err_underflow=1, no stk_pop.
- Fill with 8 PUSHes (0x01..0x08); a 9th PUSH 0xFF -> resp_err=1, err_overflow=1, depth stays 8; SWAP 0xAA -> returns 0x08, depth 8, then PEEK returns 0xAA.
- Hold resp_ready=0 for 5 cycles after a POP -> resp_valid/resp_data stable, req_ready=0, depth decremented once only; release -> IDLE next cycle.
- err_overflow set, then err_clr with a simultaneous full PUSH -> flag stays 1; err_clr alone on the next cycle -> 0.
- Assert rst=0 during SWAP in PUSH_CYC -> strobes drop immediately, depth=0, no resp_valid after release.
